keycode_envelope_gen: RTL

Consumes the 8-bit USB HID keycode driven by the keycode PIO and turns it into a playable voice control stream. It maps keycodes to musical notes and produces a 24-bit oscillator phase increment. It runs a sample-rate ADSR amplitude envelope and raises gate/note_on indications. It sits between the keycode PIO and the NCO/oscillator and amplitude multiplier of the synth datapath.

---
 rtl/keycode_envelope_gen_pkg.sv | 42 ++++
 rtl/keycode_envelope_gen_if.sv | 14 +
 rtl/keycode_envelope_gen_note_rom.sv | 29 ++
 rtl/keycode_envelope_gen.sv | 89 ++++++++
 4 files changed

// File: rtl/keycode_envelope_gen_pkg.sv
// keycode_envelope_gen_pkg: shared widths, envelope states, HID keycodes and note phase increments
package keycode_envelope_gen_pkg;
    localparam int ENV_W   = 16;
    localparam int PHASE_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } env_state_t;

    localparam logic [7:0] KC_A = 8'h04;
    localparam logic [7:0] KC_W = 8'h1A;
    localparam logic [7:0] KC_S = 8'h16;
    localparam logic [7:0] KC_E = 8'h08;
    localparam logic [7:0] KC_D = 8'h07;
    localparam logic [7:0] KC_F = 8'h09;
    localparam logic [7:0] KC_T = 8'h17;
    localparam logic [7:0] KC_G = 8'h0A;
    localparam logic [7:0] KC_Y = 8'h1C;
    localparam logic [7:0] KC_H = 8'h0B;
    localparam logic [7:0] KC_U = 8'h18;
    localparam logic [7:0] KC_J = 8'h0D;
    localparam logic [7:0] KC_K = 8'h0E;

    // round(f * 2^24 / 48000), equal temperament, A4 = 440 Hz
    localparam logic [PHASE_W-1:0] INC_C4  = 24'd91445;
    localparam logic [PHASE_W-1:0] INC_CS4 = 24'd96882;
    localparam logic [PHASE_W-1:0] INC_D4  = 24'd102643;
    localparam logic [PHASE_W-1:0] INC_DS4 = 24'd108747;
    localparam logic [PHASE_W-1:0] INC_E4  = 24'd115213;
    localparam logic [PHASE_W-1:0] INC_F4  = 24'd122064;
    localparam logic [PHASE_W-1:0] INC_FS4 = 24'd129322;
    localparam logic [PHASE_W-1:0] INC_G4  = 24'd137012;
    localparam logic [PHASE_W-1:0] INC_GS4 = 24'd145160;
    localparam logic [PHASE_W-1:0] INC_A4  = 24'd153791;
    localparam logic [PHASE_W-1:0] INC_AS4 = 24'd162936;
    localparam logic [PHASE_W-1:0] INC_B4  = 24'd172625;
    localparam logic [PHASE_W-1:0] INC_C5  = 24'd182890;
endpackage

// File: rtl/keycode_envelope_gen_if.sv
// keycode_envelope_gen_if: keycode/sample strobe in, voice control stream out
interface keycode_envelope_gen_if;
    import keycode_envelope_gen_pkg::*;
    logic [7:0]         keycode;
    logic               sample_en;
    logic [PHASE_W-1:0] phase_inc;
    logic [ENV_W-1:0]   env_level;
    logic               gate;
    logic               note_on;
    logic               active;

    modport master (output keycode, sample_en, input phase_inc, env_level, gate, note_on, active);
    modport slave  (input keycode, sample_en, output phase_inc, env_level, gate, note_on, active);
endinterface

// File: rtl/keycode_envelope_gen_note_rom.sv
// keycode_note_rom: maps a one-octave HID key layout to oscillator phase increments
module keycode_note_rom
    import keycode_envelope_gen_pkg::*;
(
    input  logic [7:0]         keycode_i,
    output logic               valid_o,
    output logic [PHASE_W-1:0] phase_inc_o
);
    always_comb begin
        valid_o     = 1'b1;
        phase_inc_o = '0;
        case (keycode_i)
            KC_A:    phase_inc_o = INC_C4;
            KC_W:    phase_inc_o = INC_CS4;
            KC_S:    phase_inc_o = INC_D4;
            KC_E:    phase_inc_o = INC_DS4;
            KC_D:    phase_inc_o = INC_E4;
            KC_F:    phase_inc_o = INC_F4;
            KC_T:    phase_inc_o = INC_FS4;
            KC_G:    phase_inc_o = INC_G4;
            KC_Y:    phase_inc_o = INC_GS4;
            KC_H:    phase_inc_o = INC_A4;
            KC_U:    phase_inc_o = INC_AS4;
            KC_J:    phase_inc_o = INC_B4;
            KC_K:    phase_inc_o = INC_C5;
            default: valid_o     = 1'b0;
        endcase
    end
endmodule

// File: rtl/keycode_envelope_gen.sv
// keycode_envelope_gen: keycode change detection, note selection and sample-rate ADSR envelope
module keycode_envelope_gen
    import keycode_envelope_gen_pkg::*;
#(
    parameter logic [ENV_W-1:0] ATTACK_STEP   = 16'd256,
    parameter logic [ENV_W-1:0] DECAY_STEP    = 16'd16,
    parameter logic [ENV_W-1:0] SUSTAIN_LEVEL = 16'hC000,
    parameter logic [ENV_W-1:0] RELEASE_STEP  = 16'd32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    keycode_envelope_gen_if.slave bus
);
    logic [7:0]         kc_q, kc_prev_q;
    env_state_t         state_q, state_d;
    logic [ENV_W-1:0]   level_q, level_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               note_on_q, note_on_d;
    logic               rom_valid, evt;
    logic [PHASE_W-1:0] rom_inc;
    logic [ENV_W:0]     up, dn_dec, dn_rel;
    logic               att_top, dec_hit, rel_hit;

    keycode_note_rom u_rom (.keycode_i(kc_q), .valid_o(rom_valid), .phase_inc_o(rom_inc));

    assign evt     = kc_q != kc_prev_q;
    // one extra bit so saturation and floor are detected before truncation
    assign up      = {1'b0, level_q} + {1'b0, ATTACK_STEP};
    assign dn_dec  = {1'b0, level_q} - {1'b0, DECAY_STEP};
    assign dn_rel  = {1'b0, level_q} - {1'b0, RELEASE_STEP};
    assign att_top = up >= {1'b0, {ENV_W{1'b1}}};
    assign dec_hit = dn_dec[ENV_W] || (dn_dec[ENV_W-1:0] <= SUSTAIN_LEVEL);
    assign rel_hit = dn_rel[ENV_W] || (dn_rel[ENV_W-1:0] == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q      <= '0;
            kc_prev_q <= '0;
            state_q   <= ST_IDLE;
            level_q   <= '0;
            phase_q   <= '0;
            note_on_q <= 1'b0;
        end else begin
            kc_q      <= bus.keycode;
            kc_prev_q <= kc_q;
            state_q   <= state_d;
            level_q   <= level_d;
            phase_q   <= phase_d;
            note_on_q <= note_on_d;
        end
    end

    // an event always wins over a level step in the same cycle
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        phase_d   = phase_q;
        note_on_d = 1'b0;
        if (evt && rom_valid) begin
            phase_d   = rom_inc;
            note_on_d = 1'b1;
            state_d   = ST_ATTACK;
        end else if (evt) begin
            state_d = (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN}) ? ST_RELEASE : state_q;
        end else if (bus.sample_en) begin
            case (state_q)
                ST_ATTACK: begin
                    level_d = att_top ? {ENV_W{1'b1}} : up[ENV_W-1:0];
                    state_d = att_top ? ST_DECAY : ST_ATTACK;
                end
                ST_DECAY: begin
                    level_d = dec_hit ? SUSTAIN_LEVEL : dn_dec[ENV_W-1:0];
                    state_d = dec_hit ? ST_SUSTAIN : ST_DECAY;
                end
                ST_RELEASE: begin
                    level_d = rel_hit ? '0 : dn_rel[ENV_W-1:0];
                    state_d = rel_hit ? ST_IDLE : ST_RELEASE;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase_inc = phase_q;
    assign bus.env_level = level_q;
    assign bus.note_on   = note_on_q;
    assign bus.gate      = state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN};
    assign bus.active    = state_q != ST_IDLE;
endmodule
